onehot_index_decoder: RTL and testbench

ONEHOT_INDEX_DECODER -- requirements
Module: onehot_index_decoder

---
 rtl/onehot_index_decoder_if.sv | 23 ++
 rtl/onehot_index_decoder.sv | 128 ++++++++++++
 tb/tb_onehot_index_decoder.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/onehot_index_decoder_if.sv
// Stream bundle for the one-hot index decoder: an upstream word channel and a
// downstream result channel, both valid/ready.
interface onehot_index_decoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_onehot;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_index;
   logic        out_none;
   logic        out_err;

   // master: the producer/consumer side; slave: the decoder itself
   modport master (
      output in_valid, in_onehot, out_ready,
      input  in_ready, out_valid, out_index, out_none, out_err
   );

   modport slave (
      input  in_valid, in_onehot, out_ready,
      output in_ready, out_valid, out_index, out_none, out_err
   );
endinterface

// File: rtl/onehot_index_decoder.sv
// Two-stage elastic decoder turning a 32-bit one-hot word into a binary index,
// flagging all-zero and multi-hot words and counting multi-hot results delivered.
module onehot_index_decoder #(
   parameter int COUNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   onehot_index_decoder_if.slave  bus,
   input  logic                   clr_err,
   output logic [COUNT_W-1:0]     err_count
);

   // Handshake: a transfer happens on any cycle where valid and ready are both 1;
   // valid never depends on ready, and payload holds while valid=1 and ready=0.

   localparam logic [COUNT_W-1:0] CNT_MAX = '1;

   // stage 1: per-byte partials
   logic            s1_valid;
   logic [3:0]      s1_any;
   logic [3:0]      s1_multi;
   logic [3:0][2:0] s1_idx;

   // stage 2: final result
   logic            s2_valid;
   logic [4:0]      s2_index;
   logic            s2_none;
   logic            s2_err;

   logic            s2_advance;
   logic            s1_advance;
   logic            in_ready_int;
   logic            in_fire;
   logic            out_fire;

   logic [3:0]      byte_any;
   logic [3:0]      byte_multi;
   logic [3:0][2:0] byte_idx;

   logic [4:0]      m_index;
   logic            m_none;
   logic            m_err;

   assign s2_advance   = ~s2_valid | bus.out_ready;
   assign s1_advance   = s2_advance;
   assign in_ready_int = ~rst & (~s1_valid | s1_advance);
   assign in_fire      = bus.in_valid & in_ready_int;
   assign out_fire     = s2_valid & bus.out_ready;

   assign bus.in_ready  = in_ready_int;
   assign bus.out_valid = s2_valid;
   assign bus.out_index = s2_index;
   assign bus.out_none  = s2_none;
   assign bus.out_err   = s2_err;

   // Per byte: any bit set, more than one bit set, and highest set bit position.
   always_comb begin
      byte_any   = '0;
      byte_multi = '0;
      byte_idx   = '0;
      for (int i = 0; i < 4; i++) begin
         byte_any[i]   = |bus.in_onehot[8*i +: 8];
         byte_multi[i] = |(bus.in_onehot[8*i +: 8] & (bus.in_onehot[8*i +: 8] - 8'd1));
         for (int b = 0; b < 8; b++) begin
            if (bus.in_onehot[8*i + b]) begin
               byte_idx[i] = 3'(b);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_any   <= '0;
         s1_multi <= '0;
         s1_idx   <= '0;
      end else begin
         if (in_ready_int) begin
            s1_valid <= bus.in_valid;
         end
         if (in_fire) begin
            s1_any   <= byte_any;
            s1_multi <= byte_multi;
            s1_idx   <= byte_idx;
         end
      end
   end

   // Highest non-empty byte wins, matching the encoder's bit-31-first priority;
   // a word is multi-hot if any byte is, or if two bytes are non-empty.
   always_comb begin
      m_index = '0;
      for (int i = 0; i < 4; i++) begin
         if (s1_any[i]) begin
            m_index = {2'(i), s1_idx[i]};
         end
      end
      m_none = ~|s1_any;
      m_err  = (|s1_multi) | (|(s1_any & (s1_any - 4'd1)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_index <= '0;
         s2_none  <= 1'b0;
         s2_err   <= 1'b0;
      end else if (s2_advance) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_index <= m_index;
            s2_none  <= m_none;
            s2_err   <= m_err;
         end
      end
   end

   // Clear beats a same-cycle increment; saturate rather than wrap.
   always_ff @(posedge clk) begin
      if (rst || clr_err) begin
         err_count <= '0;
      end else if (out_fire && s2_err && (err_count != CNT_MAX)) begin
         err_count <= err_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_onehot_index_decoder.sv
// Scoreboard bench for onehot_index_decoder: directed vectors plus a random
// stream, checked by a monitor that pops expected results on every output transfer.
module tb_onehot_index_decoder;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clr_err = 1'b0;
   logic [CW-1:0] err_count;

   onehot_index_decoder_if bus();

   onehot_index_decoder #(.COUNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .clr_err   (clr_err),
      .err_count (err_count)
   );

   // clock / reset
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int in_stall = 0;
   int ready_mode = 0;
   bit lat_mode = 1'b0;

   logic [6:0]    exp_q[$];
   int            stamp_q[$];
   logic [CW-1:0] model_cnt;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] ref_dec(input logic [31:0] w);
      int hi = -1;
      int pop = 0;
      for (int i = 0; i < 32; i++) begin
         if (w[i]) begin
            hi = i;
            pop++;
         end
      end
      return {(hi < 0) ? 5'd0 : 5'(hi), (hi < 0), (pop > 1)};
   endfunction

   // out_ready driver: 0 always-1, 1 pattern 1,0,0,1, 2 random, 3 held low
   initial begin
      int phase = 0;
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         phase++;
         case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
            2:       bus.out_ready = 1'($urandom_range(1));
            default: bus.out_ready = 1'b0;
         endcase
      end
   end

   // driver tasks
   task automatic send(input logic [31:0] w, input logic [4:0] ei, input logic en, input logic ee);
      int budget = 0;
      bus.in_valid  = 1'b1;
      bus.in_onehot = w;
      do begin
         @(negedge clk);
         budget++;
      end while (!(bus.in_ready && !rst) && budget < 200);
      if (!(bus.in_ready && !rst)) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout actual=in_ready_low required=accept word %08h", w);
      end else begin
         exp_q.push_back({ei, en, ee});
         stamp_q.push_back(cyc);
      end
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.in_onehot = 32'hdeadbeef;
   endtask

   task automatic drain();
      int budget = 0;
      while (exp_q.size() != 0 && budget < 2000) begin
         @(negedge clk);
         budget++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
         exp_q.delete();
         stamp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   // scoreboard monitor
   initial begin
      bit         stall_prev = 1'b0;
      logic [6:0] held = '0;
      logic [6:0] got;
      logic [6:0] exp;
      int         st;
      model_cnt = '0;
      forever begin
         @(negedge clk);
         check("err_count", 32'(err_count), 32'(model_cnt));
         if (rst) begin
            exp_q.delete();
            stamp_q.delete();
            stall_prev = 1'b0;
            model_cnt  = '0;
         end else begin
            got = {bus.out_index, bus.out_none, bus.out_err};
            if (!bus.in_ready) in_stall++;
            if (stall_prev && bus.out_valid) check("hold_stable", 32'(got), 32'(held));
            stall_prev = bus.out_valid && !bus.out_ready;
            held = got;
            exp = '0;
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output actual=%02h required=no output", got);
               end else begin
                  exp = exp_q.pop_front();
                  st  = stamp_q.pop_front();
                  check("out_index", 32'(bus.out_index), 32'(exp[6:2]));
                  check("out_none", 32'(bus.out_none), 32'(exp[1]));
                  check("out_err", 32'(bus.out_err), 32'(exp[0]));
                  if (lat_mode) check("latency", 32'(cyc - st), 32'd2);
               end
            end
            if (clr_err) model_cnt = '0;
            else if (exp[0] && model_cnt != '1) model_cnt = model_cnt + 1'b1;
         end
      end
   end

   // directed and random stimulus
   initial begin
      logic [31:0] vec_w[8];
      logic [4:0]  vec_i[8];
      logic        vec_n[8];
      logic [31:0] w;
      logic [6:0]  e;
      int          st0;

      vec_w = '{32'h00000001, 32'h00000080, 32'h00000100, 32'h00008000,
                32'h00010000, 32'h00000000, 32'h00400000, 32'h40000000};
      vec_i = '{5'd0, 5'd7, 5'd8, 5'd15, 5'd16, 5'd0, 5'd22, 5'd30};
      vec_n = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

      bus.in_valid  = 1'b0;
      bus.in_onehot = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_fields", 32'({bus.out_index, bus.out_none, bus.out_err}), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;

      // walking one, back-to-back, fixed latency
      lat_mode = 1'b1;
      for (int k = 0; k < 32; k++) send(32'd1 << k, 5'(k), 1'b0, 1'b0);
      drain();
      lat_mode = 1'b0;

      // zero then two-bit word
      send(32'h00000000, 5'd0, 1'b1, 1'b0);
      send(32'h80000001, 5'd31, 1'b0, 1'b1);
      drain();
      check("err_count_after_pair", 32'(err_count), 32'd1);

      // stalls with out_ready 1,0,0,1
      ready_mode = 1;
      st0 = in_stall;
      for (int i = 0; i < 8; i++) send(vec_w[i], vec_i[i], vec_n[i], 1'b0);
      drain();
      ready_mode = 0;
      check("in_ready_dropped", 32'(in_stall > st0), 32'd1);

      // saturation at 15, then clear coincident with a multi-hot transfer
      for (int i = 0; i < 20; i++) send(32'h3 << (i % 30), 5'((i % 30) + 1), 1'b0, 1'b1);
      drain();
      check("err_count_saturated", 32'(err_count), 32'd15);
      send(32'h00A00000, 5'd23, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      check("clr_coincident_valid", 32'(bus.out_valid && bus.out_err), 32'd1);
      clr_err = 1'b1;
      @(posedge clk);
      #1;
      clr_err = 1'b0;
      @(negedge clk);
      check("err_count_cleared", 32'(err_count), 32'd0);
      @(posedge clk);
      #1;

      // reset with two words in flight
      send(32'h00000300, 5'd9, 1'b0, 1'b1);
      ready_mode = 3;
      send(32'h00000004, 5'd2, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      check("midrst_err_count", 32'(err_count), 32'd0);
      ready_mode = 0;
      repeat (10) @(negedge clk);
      @(posedge clk);
      #1;

      // random mix with random backpressure
      ready_mode = 2;
      for (int n = 0; n < 10000; n++) begin
         int r;
         int a;
         int b;
         if ($urandom_range(9) == 0) begin
            @(posedge clk);
            #1;
         end
         r = $urandom_range(99);
         if (r < 70) begin
            w = 32'd1 << $urandom_range(31);
         end else if (r < 85) begin
            w = 32'd0;
         end else begin
            a = $urandom_range(31);
            b = (a + 1 + $urandom_range(30)) % 32;
            w = ($urandom() & $urandom()) | (32'd1 << a) | (32'd1 << b);
         end
         e = ref_dec(w);
         send(w, e[6:2], e[1], e[0]);
      end
      drain();
      ready_mode = 0;
      repeat (4) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
